seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Sequential unsigned shift-add multiplier: accepts two LEN-bit operands on a start request, computes their 2·LEN-bit product one bit per clock, then pulses a one-cycle finish flag with the result held on a registered output. It is a standalone arithmetic unit that a controller drives through a simple start/finish handshake. A checker (judge) instantiated alongside it in verification compares each result with a golden product.

## Interface
- LEN, default 32: operand width in bits; product width is 2·LEN. Legal for LEN ≥ 2.
- clk  input  1  single clock; all state changes on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- multiplicand  input  LEN  unsigned operand A; sampled only when a start is accepted.
- multiplier  input  LEN  unsigned operand B; sampled only when a start is accepted.
- start  input  1  request; level-sampled on the rising edge.
- product  output  2·LEN  registered result of the last completed operation.
- finish  output  1  one-cycle pulse; product is valid and new in that cycle.

## Operation
- States: IDLE, WORK, DONE. Reset state is IDLE.
- IDLE: if start=1 at the edge, latch multiplicand into A_reg, load working register W (2·LEN+1 bits) = {carry=0, upper=0, lower=multiplier}, clear step counter, go to WORK. Otherwise stay.
- WORK, each edge: if W[0]=1, sum = upper + A_reg (LEN+1 bits, carry kept); else sum = {0, upper}. W <= {sum, lower} >> 1. Increment the counter. After the LEN-th step, go to DONE.
- Entering DONE: product <= final W[2·LEN-1:0]; finish=1.
- DONE: unconditionally return to IDLE on the next edge; finish returns to 0.
- start while in WORK or DONE is ignored; operand changes after acceptance have no effect.
- start held high continuously means a new operation is accepted on the first edge back in IDLE.
- product holds its value until the next completion; it never shows partial sums.
- Arithmetic is unsigned, full width, and never overflows, because the product width is 2·LEN.

## Timing
- Reset (rstn=0, asynchronous): state=IDLE; product=0; finish=0; W, A_reg and the counter are 0. Reset has immediate effect mid-operation; the operation in flight is discarded and no finish is produced.
- Edge E0: start accepted in IDLE.
- Edges E1..E_LEN: the LEN add-shift steps.
- After E_LEN: finish=1 and product is valid for exactly one cycle.
- After E_LEN+1: finish=0 and state is IDLE.
- E_LEN+2: earliest acceptance of the next start.
- Throughput is one operation per LEN+2 cycles.
- Latency from the accepting edge to the finish pulse is LEN edges.

## Structure
- Shared package holds:
  - the state enum (IDLE, WORK, DONE);
  - a localparam or function giving the counter width, $clog2(LEN+1).
- One natural sub-module: mul_step, combinational. Its inputs are W and A_reg; its output is the next W (a conditional (LEN+1)-bit add followed by a right shift). The top level holds the FSM, the counter and the registers.

## Test plan
- Basic: after reset, start with 3 × 5 → finish pulses exactly 32 edges after acceptance, with product = 64'd15; finish is low in the next cycle.
- Extremes: 0xFFFFFFFF × 0xFFFFFFFF → product = 0xFFFFFFFE00000001. 0 × 0xDEADBEEF → product = 0. 1 × 0x80000000 → product = 0x0000000080000000.
- Busy-ignore: accept 7 × 9, then during WORK drive start=1 with operands 2 × 2 → the first finish gives 63. The next operation is accepted only after the return to IDLE and yields 4.
- Continuous start: hold start=1 with operands changing every cycle → finish pulses every 34 cycles. Each product equals the operands present at its accepting edge.
- Reset mid-operation: assert rstn=0 at step 10 of a WORK sequence → product=0 and finish=0 immediately. No finish appears afterwards. The next start works normally.
- Random: 64 random operand pairs → the judge reports no mismatch on any finish pulse.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package seq_multiplier_pkg;

  // Controller states: waiting for a request, iterating, presenting the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORK = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the step counter; it must be able to hold the value len.
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/finish handshake and operand/result bus of the multiplier.
interface seq_multiplier_if #(
  parameter int LEN = 32
);

  logic               start;
  logic [LEN-1:0]     multiplicand;
  logic [LEN-1:0]     multiplier;
  logic [2*LEN-1:0]   product;
  logic               finish;

  // Controller side: issues requests and observes results.
  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  product,
    input  finish
  );

  // Multiplier side: accepts requests and returns results.
  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output product,
    output finish
  );

endinterface

// File: rtl/seq_multiplier_mul_step.sv
// One add-shift iteration of the multiplier. The working word is laid out as
// {carry, upper, lower}; lower still holds the unconsumed multiplier bits and
// its LSB decides whether the multiplicand is added into the upper half.
module seq_multiplier_mul_step #(
  parameter int LEN = 32
) (
  input  logic [2*LEN:0]   w_cur,
  input  logic [LEN-1:0]   a_reg,
  output logic [2*LEN:0]   w_next
);

  logic [LEN:0] acc;
  logic [LEN:0] sum;

  // The carry bit is always zero on entry because the previous shift cleared
  // it, so {carry, upper} is simply upper widened to LEN+1 bits.
  assign acc = w_cur[2*LEN:LEN];

  // Conditional add of the multiplicand, keeping the carry out.
  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sum = acc;
    if (w_cur[0]) begin
      sum = acc + {1'b0, a_reg};
    end
  end

  // Right shift of {sum, lower}; the consumed multiplier bit drops out.
  assign w_next = {1'b0, sum, w_cur[LEN-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier. A start in IDLE captures the
// operands, LEN add-shift steps follow, and finish pulses for one cycle in
// DONE while product holds the new result until the next completion.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  seq_multiplier_if.slave      bus
);

  localparam int WW = 2 * LEN + 1;
  localparam int CW = cnt_width(LEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(LEN - 1);

  state_t            state;
  state_t            state_next;

  logic [WW-1:0]     w;
  logic [WW-1:0]     w_next;
  logic [LEN-1:0]    a_reg;
  logic [CW-1:0]     count;
  logic [2*LEN-1:0]  product_q;

  logic              load;
  logic              step;
  logic              last_step;

  assign last_step = (count == LAST_STEP);

  // Combinational datapath for one iteration.
  seq_multiplier_mul_step #(
    .LEN (LEN)
  ) u_mul_step (
    .w_cur  (w),
    .a_reg  (a_reg),
    .w_next (w_next)
  );

  // State register; reset discards any operation in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and datapath controls; start is only honoured in IDLE.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = WORK;
        end
      end
      WORK: begin
        step = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, iteration and step counting.
  // NOTE: these are plain registers rather than a memory, so they all take an
  // explicit reset value and leave no X into the datapath after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_reg <= '0;
      w     <= '0;
      count <= '0;
    end else if (load) begin
      a_reg <= bus.multiplicand;
      w     <= {{(LEN + 1){1'b0}}, bus.multiplier};
      count <= '0;
    end else if (step) begin
      w     <= w_next;
      count <= count + CW'(1);
    end
  end

  // Result register: updated only by the final step, so partial sums never
  // become visible on product.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      product_q <= '0;
    end else if (step && last_step) begin
      product_q <= w_next[2*LEN-1:0];
    end
  end

  assign bus.product = product_q;
  assign bus.finish  = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and table-driven bench for seq_multiplier (LEN = 32).
module tb_seq_multiplier;

  localparam int LEN = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_multiplier_if #(.LEN(LEN)) bus ();

  seq_multiplier #(.LEN(LEN)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fa(input int e);
    return 32'(32'h9E37_79B9 * (e + 1));
  endfunction

  function automatic logic [31:0] fb(input int e);
    return 32'hFFFF_0000 ^ 32'(e * 1103515245 + 12345);
  endfunction

  // One isolated operation from IDLE: checks latency, result and pulse width.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string name);
    int n;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(negedge clk);
    bus.start        = 1'b0;
    bus.multiplicand = ~a;
    bus.multiplier   = b ^ 32'h1234_5678;
    n = 0;
    while (!bus.finish && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(LEN));
    check({name, " product"}, bus.product, exp);
    @(negedge clk);
    check({name, " finish drop"}, {63'b0, bus.finish}, 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    int last_fin;
    int nfin;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{a: 32'd3,          b: 32'd5,          exp: 64'd15,                  name: "basic"};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  exp: 64'hFFFF_FFFE_0000_0001, name: "max"};
    vecs[2] = '{a: 32'd0,          b: 32'hDEAD_BEEF,  exp: 64'd0,                   name: "zero"};
    vecs[3] = '{a: 32'd1,          b: 32'h8000_0000,  exp: 64'h0000_0000_8000_0000, name: "one_msb"};
    vecs[4] = '{a: 32'hDEAD_BEEF,  b: 32'd1,          exp: 64'h0000_0000_DEAD_BEEF, name: "by_one"};
    vecs[5] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  exp: 64'h0000_0001_0000_0000, name: "carry_up"};

    rstn             = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (2) @(negedge clk);
    check("reset product", bus.product, 64'd0);
    check("reset finish", {63'b0, bus.finish}, 64'd0);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
    end

    // Busy-ignore: a second request held through WORK/DONE waits for IDLE.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 32'd7; bus.multiplier = 32'd9;
    @(negedge clk);
    bus.multiplicand = 32'd2; bus.multiplier = 32'd2;
    n = 0;
    while (!bus.finish && n < 100) begin @(negedge clk); n++; end
    check("busy latency", 64'(n), 64'(LEN));
    check("busy first product", bus.product, 64'd63);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.finish && n < 100);
    bus.start = 1'b0;
    check("busy interval", 64'(n), 64'(LEN + 2));
    check("busy second product", bus.product, 64'd4);
    @(negedge clk);
    check("busy finish drop", {63'b0, bus.finish}, 64'd0);

    // Continuous start with operands changing on every edge.
    last_fin = -1;
    nfin     = 0;
    for (int e = 0; e < 106; e++) begin
      @(negedge clk);
      if (e > 0 && bus.finish) begin
        nfin++;
        check("cont product", bus.product,
              {32'b0, fa(e - 1 - LEN)} * {32'b0, fb(e - 1 - LEN)});
        if (last_fin >= 0) check("cont interval", 64'(e - 1 - last_fin), 64'(LEN + 2));
        last_fin = e - 1;
      end
      bus.start = 1'b1; bus.multiplicand = fa(e); bus.multiplier = fb(e);
    end
    bus.start = 1'b0;
    check("cont finish count", 64'(nfin), 64'd3);
    n = 0;
    while (!bus.finish && n < 100) begin @(negedge clk); n++; end
    check("cont tail product", bus.product, {32'b0, fa(102)} * {32'b0, fb(102)});
    @(negedge clk);

    // Reset in the middle of an operation.
    bus.start = 1'b1; bus.multiplicand = 32'd11; bus.multiplier = 32'd13;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midreset product", bus.product, 64'd0);
    check("midreset finish", {63'b0, bus.finish}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    nfin = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.finish) nfin++;
    end
    check("midreset no finish", 64'(nfin), 64'd0);
    run_op(32'd6, 32'd7, 64'd42, "after_reset");

    // Random operands against the bench's own 64-bit product.
    for (int i = 0; i < 64; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(ra, rb, {32'b0, ra} * {32'b0, rb}, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
